// File: rtl/systolic_deskew.sv
// Output-side deskew for a systolic array: lane i is delayed LANES-1-i cycles so the
// diagonal result wavefront lands as one registered parallel beat, with row/tile tracking.

module systolic_deskew_lane #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  output logic [WIDTH-1:0] q,
  output logic             qv
);
  generate
    if (DEPTH == 0) begin : g_thru
      assign q  = d;
      assign qv = v;
    end else begin : g_dly
      logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
      logic [DEPTH-1:0]            vld_pipe;

      always_ff @(posedge clk) begin
        if (reset) begin
          dat_pipe <= '0;
          vld_pipe <= '0;
        end else begin
          dat_pipe[0] <= d;
          vld_pipe[0] <= v;
          for (int k = 1; k < DEPTH; k++) begin
            dat_pipe[k] <= dat_pipe[k-1];
            vld_pipe[k] <= vld_pipe[k-1];
          end
        end
      end

      assign q  = dat_pipe[DEPTH-1];
      assign qv = vld_pipe[DEPTH-1];
    end
  endgenerate
endmodule

module systolic_deskew #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int ROWS  = 4,
  parameter int CNT_W = $clog2(ROWS) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [CNT_W-1:0]       row_count,
  output logic                   skew_err
);
  logic [LANES-1:0][WIDTH-1:0] ad;
  logic [LANES-1:0]            av;
  logic                        beat, partial, wrap;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      systolic_deskew_lane #(.WIDTH(WIDTH), .DEPTH(LANES-1-i)) u_lane (
        .clk   (clk),
        .reset (reset),
        .d     (in_data[i*WIDTH +: WIDTH]),
        .v     (in_valid[i]),
        .q     (ad[i]),
        .qv    (av[i])
      );
    end
  endgenerate

  // A beat needs every lane of the row aligned in the same cycle; anything less is dropped.
  assign beat    = &av;
  assign partial = (|av) && !beat;
  assign wrap    = (row_count == CNT_W'(ROWS-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      row_count <= '0;
      skew_err  <= 1'b0;
    end else begin
      out_valid <= beat;
      out_last  <= beat && wrap;
      if (beat) begin
        out_data  <= ad;
        row_count <= wrap ? '0 : row_count + CNT_W'(1);
      end
      if (partial) skew_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_systolic_deskew.sv
// Directed + random bench for systolic_deskew; a cycle-indexed input history serves as
// the reference, expected beats are derived from per-lane latency and reset times.

module tb_systolic_deskew;
  localparam int W  = 16;
  localparam int L  = 4;
  localparam int R  = 4;
  localparam int CW = $clog2(R) + 1;
  localparam int N  = 1024;

  logic           clk = 1'b0;
  logic           reset;
  logic [L*W-1:0] in_data, out_data;
  logic [L-1:0]   in_valid;
  logic           out_valid, out_last, skew_err;
  logic [CW-1:0]  row_count;

  logic [W-1:0]   in_data1, out_data1;
  logic           in_valid1, out_valid1, out_last1, skew_err1;
  logic [0:0]     row_count1;

  always #5 clk = ~clk;

  systolic_deskew #(.WIDTH(W), .LANES(L), .ROWS(R)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .row_count(row_count), .skew_err(skew_err)
  );

  systolic_deskew #(.WIDTH(W), .LANES(1), .ROWS(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .out_data(out_data1), .out_valid(out_valid1), .out_last(out_last1),
    .row_count(row_count1), .skew_err(skew_err1)
  );

  int n_assert = 0, n_fail = 0;
  int cyc = 0, last_rst = -1, beats = 0, lasts = 0;
  logic [L-1:0]   sv [N];
  logic [L*W-1:0] sd [N];
  logic [L-1:0]   hv [N];
  logic [L*W-1:0] hd [N];
  logic [L*W-1:0] last_beat;

  logic [L*W-1:0] m_data;
  logic           m_valid, m_last, m_err;
  int             m_cnt;
  logic [W-1:0]   m1_data;
  logic           m1_valid;
  logic           nxt_v1;
  logic [W-1:0]   nxt_d1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Lane i of a row starting at t is valid at t+i (plus one if that lane is the late one).
  task automatic add_row(input int t, input logic [L*W-1:0] d, input int late);
    for (int i = 0; i < L; i++) begin
      int c;
      c = t + i + ((i == late) ? 1 : 0);
      sv[c][i] = 1'b1;
      sd[c][i*W +: W] = sd[c][i*W +: W] | d[i*W +: W];
    end
  endtask

  task automatic tick(input bit r);
    logic [L-1:0]   av;
    logic [L*W-1:0] ad;
    @(negedge clk);
    reset     = r;
    in_valid  = sv[cyc];
    in_data   = sd[cyc];
    in_valid1 = nxt_v1;
    in_data1  = nxt_d1;
    @(posedge clk);
    hv[cyc] = in_valid;
    hd[cyc] = in_data;
    if (r) begin
      m_data = '0; m_valid = 0; m_last = 0; m_cnt = 0; m_err = 0;
      m1_data = '0; m1_valid = 0;
      last_rst = cyc;
    end else begin
      av = '0; ad = '0;
      // Lane i sampled at s reaches the output edge at s+L-1-i, unless a reset came after s.
      for (int i = 0; i < L; i++) begin
        int s;
        s = cyc - (L - 1 - i);
        if (s > last_rst && s >= 0) begin
          av[i] = hv[s][i];
          ad[i*W +: W] = hd[s][i*W +: W];
        end
      end
      if (&av) begin
        m_valid = 1; m_data = ad; m_last = (m_cnt == R-1); m_cnt = (m_cnt + 1) % R;
      end else begin
        m_valid = 0; m_last = 0;
        if (av != '0) m_err = 1;
      end
      m1_valid = in_valid1;
      if (in_valid1) m1_data = in_data1;
    end
    cyc++;
    nxt_v1 = 1'($urandom_range(0, 1));
    nxt_d1 = W'($urandom);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("out_last",  64'(out_last),  64'(m_last));
    chk("row_count", 64'(row_count), 64'(m_cnt));
    chk("skew_err",  64'(skew_err),  64'(m_err));
    chk("l1_valid",  64'(out_valid1), 64'(m1_valid));
    chk("l1_data",   64'(out_data1),  64'(m1_data));
    chk("l1_last",   64'(out_last1),  64'(m1_valid));
    chk("l1_count",  64'(row_count1), 64'(0));
    chk("l1_err",    64'(skew_err1),  64'(0));
    if (out_valid === 1'b1) begin beats++; last_beat = out_data; end
    if (out_last === 1'b1) lasts++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick(1'b0);
  endtask

  function automatic logic [L*W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int b0, l0, t;
    logic [L*W-1:0] d;
    for (int c = 0; c < N; c++) begin sv[c] = '0; sd[c] = '0; end
    nxt_v1 = 0; nxt_d1 = '0; last_beat = '0;

    // Reset state, then a single LANES=1 beat of 0xBEEF
    tick(1'b1); tick(1'b1);
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_count", 64'(row_count), 64'(0));
    nxt_v1 = 1'b1; nxt_d1 = 16'hBEEF;
    tick(1'b0);
    chk("l1_beef_v", 64'(out_valid1), 64'(1));
    chk("l1_beef_d", 64'(out_data1), 64'h0000_0000_0000_BEEF);

    // Single row
    b0 = beats;
    add_row(cyc + 1, 64'h0013_0012_0011_0010, -1);
    run(9);
    chk("A_beats", 64'(beats - b0), 64'(1));
    chk("A_data", 64'(last_beat), 64'h0013_0012_0011_0010);
    chk("A_err", 64'(skew_err), 64'(0));

    // Four back-to-back rows, one tile
    tick(1'b1);
    b0 = beats; l0 = lasts; t = cyc + 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < L; i++) d[i*W +: W] = W'(r*16 + i);
      add_row(t + r, d, -1);
    end
    run(12);
    chk("B_beats", 64'(beats - b0), 64'(4));
    chk("B_lasts", 64'(lasts - l0), 64'(1));
    chk("B_data", 64'(last_beat), 64'h0033_0032_0031_0030);
    chk("B_count", 64'(row_count), 64'(0));

    // Misaligned row then a good row
    tick(1'b1);
    b0 = beats;
    add_row(cyc + 1, rnd(), 2);
    add_row(cyc + 10, rnd(), -1);
    run(20);
    chk("C_beats", 64'(beats - b0), 64'(1));
    chk("C_err", 64'(skew_err), 64'(1));

    // Reset one cycle after lane 0 of a row
    tick(1'b1);
    b0 = beats;
    add_row(cyc + 1, rnd(), -1);
    run(2);
    tick(1'b1);
    chk("D_valid", 64'(out_valid), 64'(0));
    chk("D_data", 64'(out_data), 64'(0));
    chk("D_count", 64'(row_count), 64'(0));
    run(8);
    chk("D_beats", 64'(beats - b0), 64'(0));

    // Six rows with 3 idle cycles between them
    tick(1'b1);
    b0 = beats; l0 = lasts; t = cyc + 1;
    for (int k = 0; k < 6; k++) add_row(t + 4*k, rnd(), -1);
    run(32);
    chk("E_beats", 64'(beats - b0), 64'(6));
    chk("E_lasts", 64'(lasts - l0), 64'(1));
    chk("E_count", 64'(row_count), 64'(2));
    chk("E_err", 64'(skew_err), 64'(0));

    // Random rows, occasional late lanes and resets
    tick(1'b1);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 2) == 0)
        add_row(cyc + 1, rnd(), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, L-1)) : -1);
      tick($urandom_range(0, 39) == 0);
    end
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
